// File: rtl/issue_sched_if.sv
// issue_sched_if: buffer-head, pipeline-status and issue-control signals of the dual-issue scheduler.
interface issue_sched_if;
  logic h0_valid, h1_valid;
  logic [9:0] h0_type, h1_type;
  logic h0_rf_we, h1_rf_we;
  logic [4:0] h0_rd, h1_rd, h1_raddr1, h1_raddr2;
  logic stall, flush_BR, pipe_empty, ser_done;
  logic issue_valid1, issue_valid2;
  logic [1:0] pop_cnt;
  logic ser_busy;
  modport master(
    output h0_valid, h1_valid, h0_type, h1_type, h0_rf_we, h1_rf_we, h0_rd, h1_rd,
           h1_raddr1, h1_raddr2, stall, flush_BR, pipe_empty, ser_done,
    input issue_valid1, issue_valid2, pop_cnt, ser_busy
  );
  modport slave(
    input h0_valid, h1_valid, h0_type, h1_type, h0_rf_we, h1_rf_we, h0_rd, h1_rd,
          h1_raddr1, h1_raddr2, stall, flush_BR, pipe_empty, ser_done,
    output issue_valid1, issue_valid2, pop_cnt, ser_busy
  );
endinterface

// File: rtl/issue_sched.sv
// issue_sched: dual-issue scheduler with pairing rules, CSR/ERTN/CACOP serialization and divider throttling.
module issue_sched #(
  parameter logic [9:0] SER_MASK = 10'h0B0,
  parameter int DIV_CYCLES = 34,
  parameter int CNT_W = 6
) (
  input logic clk,
  input logic rst,
  issue_sched_if.slave s
);
  localparam logic [1:0] RUN = 2'd0, DRAIN = 2'd1, WAIT = 2'd2;
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);
  logic [1:0] state, state_nx;
  logic [CNT_W-1:0] div_cnt;
  logic live, gate, div_busy, ser0, ser1, md0, md1, raw, waw, run_i0, run_i1, iv1, iv2, div_go;
  always_comb begin
    gate = s.stall | s.flush_BR;
    div_busy = div_cnt != '0;
    ser0 = (s.h0_type & SER_MASK) != '0;
    ser1 = (s.h1_type & SER_MASK) != '0;
    md0 = s.h0_type[2] | s.h0_type[3];
    md1 = s.h1_type[2] | s.h1_type[3];
    raw = s.h0_rf_we & s.h0_rd != 5'd0 & (s.h0_rd == s.h1_raddr1 | s.h0_rd == s.h1_raddr2);
    waw = s.h0_rf_we & s.h1_rf_we & s.h0_rd == s.h1_rd & s.h1_rd != 5'd0;
    run_i0 = s.h0_valid & ~ser0 & ~(md0 & div_busy);
    run_i1 = run_i0 & s.h1_valid & ~ser1 & (s.h0_type == 10'h001 | s.h1_type == 10'h001)
             & ~raw & ~waw & ~(md1 & div_busy);
    // live holds every output low for the first cycle after reset release
    iv1 = live & ~gate & (state == RUN ? run_i0 : state == DRAIN & s.pipe_empty);
    iv2 = live & ~gate & state == RUN & run_i1;
    div_go = (iv1 & s.h0_type[3]) | (iv2 & s.h1_type[3]);
    state_nx = !live ? state
             : state == RUN ? (s.h0_valid & ser0 ? DRAIN : RUN)
             : state == DRAIN ? (s.flush_BR ? RUN : iv1 ? WAIT : DRAIN)
             : s.ser_done ? RUN : WAIT;
  end
  assign s.issue_valid1 = iv1;
  assign s.issue_valid2 = iv2;
  assign s.pop_cnt = {1'b0, iv1} + {1'b0, iv2};
  assign s.ser_busy = state != RUN;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      div_cnt <= '0;
      live <= 1'b0;
    end else begin
      live <= 1'b1;
      state <= state_nx;
      div_cnt <= div_go ? DIV_LOAD : div_busy ? div_cnt - 1'b1 : div_cnt;
    end
  end
endmodule

// File: tb/tb_issue_sched.sv
// tb_issue_sched: directed scenarios plus randomized traffic against a cycle-count reference model.
module tb_issue_sched;
  localparam logic [9:0] ALU = 10'h001, BR = 10'h002, MUL = 10'h004, DIV = 10'h008;
  localparam logic [9:0] CSR = 10'h010, ERTN = 10'h020, MEM = 10'h040, CACOP = 10'h080;
  localparam int DIVC = 34;
  logic clk = 1'b0, rst = 1'b1;
  int vecs = 0, errs = 0;
  logic [4:0] obs;
  issue_sched_if bus();
  issue_sched dut(.clk(clk), .rst(rst), .s(bus));
  always #5 clk = ~clk;
  assign obs = {bus.issue_valid1, bus.issue_valid2, bus.pop_cnt, bus.ser_busy};

  task automatic idle();
    bus.h0_valid = 0; bus.h0_type = ALU; bus.h0_rf_we = 0; bus.h0_rd = 0;
    bus.h1_valid = 0; bus.h1_type = ALU; bus.h1_rf_we = 0; bus.h1_rd = 0;
    bus.h1_raddr1 = 0; bus.h1_raddr2 = 0;
    bus.stall = 0; bus.flush_BR = 0; bus.pipe_empty = 0; bus.ser_done = 0;
  endtask

  task automatic set_h0(input logic [9:0] t, input logic we, input logic [4:0] rd);
    bus.h0_valid = 1; bus.h0_type = t; bus.h0_rf_we = we; bus.h0_rd = rd;
  endtask

  task automatic set_h1(input logic [9:0] t, input logic we, input logic [4:0] rd,
                        input logic [4:0] a1, input logic [4:0] a2);
    bus.h1_valid = 1; bus.h1_type = t; bus.h1_rf_we = we; bus.h1_rd = rd;
    bus.h1_raddr1 = a1; bus.h1_raddr2 = a2;
  endtask

  task automatic set_pair();
    set_h0(ALU, 1, 3); set_h1(ALU, 0, 0, 5, 6);
  endtask

  task automatic test_reset();
    idle(); set_pair(); rst = 1;
    repeat (2) @(negedge clk);
    #1 vecs++; if (obs !== 5'b00000) begin errs++; $display("FAIL reset_held: got %b expected %b", obs, 5'b00000); end
    @(negedge clk); rst = 0;
    #1 vecs++; if (obs !== 5'b00000) begin errs++; $display("FAIL reset_first_cycle: got %b expected %b", obs, 5'b00000); end
    @(negedge clk);
    #1 vecs++; if (obs !== 5'b11100) begin errs++; $display("FAIL reset_then_issue: got %b expected %b", obs, 5'b11100); end
    @(negedge clk);
  endtask

  task automatic test_pair();
    idle(); set_pair();
    #1 vecs++; if (obs !== 5'b11100) begin errs++; $display("FAIL pair: got %b expected %b", obs, 5'b11100); end
    @(negedge clk);
    idle(); set_h0(ALU, 1, 3);
    #1 vecs++; if (obs !== 5'b10010) begin errs++; $display("FAIL h0_only: got %b expected %b", obs, 5'b10010); end
    @(negedge clk);
  endtask

  task automatic test_raw();
    idle(); set_h0(ALU, 1, 7); set_h1(ALU, 0, 0, 7, 1);
    #1 vecs++; if (obs !== 5'b10010) begin errs++; $display("FAIL raw_a1: got %b expected %b", obs, 5'b10010); end
    @(negedge clk); set_h1(ALU, 0, 0, 2, 7);
    #1 vecs++; if (obs !== 5'b10010) begin errs++; $display("FAIL raw_a2: got %b expected %b", obs, 5'b10010); end
    @(negedge clk); set_h0(ALU, 1, 0); set_h1(ALU, 0, 0, 0, 0);
    #1 vecs++; if (obs !== 5'b11100) begin errs++; $display("FAIL raw_r0: got %b expected %b", obs, 5'b11100); end
    @(negedge clk); set_h0(ALU, 0, 7); set_h1(ALU, 0, 0, 7, 7);
    #1 vecs++; if (obs !== 5'b11100) begin errs++; $display("FAIL raw_no_we: got %b expected %b", obs, 5'b11100); end
    @(negedge clk); set_h0(ALU, 1, 4); set_h1(ALU, 1, 4, 1, 2);
    #1 vecs++; if (obs !== 5'b10010) begin errs++; $display("FAIL waw: got %b expected %b", obs, 5'b10010); end
    @(negedge clk); set_h1(ALU, 0, 4, 1, 2);
    #1 vecs++; if (obs !== 5'b11100) begin errs++; $display("FAIL waw_no_we: got %b expected %b", obs, 5'b11100); end
    @(negedge clk);
  endtask

  task automatic test_nonalu();
    idle(); set_h0(MUL, 1, 8); set_h1(BR, 0, 0, 1, 2);
    #1 vecs++; if (obs !== 5'b10010) begin errs++; $display("FAIL two_nonalu: got %b expected %b", obs, 5'b10010); end
    @(negedge clk); set_h1(ALU, 1, 9, 1, 2);
    #1 vecs++; if (obs !== 5'b11100) begin errs++; $display("FAIL mul_alu_pair: got %b expected %b", obs, 5'b11100); end
    @(negedge clk); idle(); set_h0(DIV, 1, 9);
    #1 vecs++; if (obs !== 5'b10010) begin errs++; $display("FAIL div_issue: got %b expected %b", obs, 5'b10010); end
    @(negedge clk); set_h0(MUL, 1, 10);
    for (int i = 1; i <= DIVC; i++) begin
      #1 vecs++; if (obs !== 5'b00000) begin errs++; $display("FAIL mul_blocked cycle %0d: got %b expected %b", i, obs, 5'b00000); end
      @(negedge clk);
    end
    #1 vecs++; if (obs !== 5'b10010) begin errs++; $display("FAIL mul_after_div: got %b expected %b", obs, 5'b10010); end
    @(negedge clk); idle();
  endtask

  task automatic test_serial();
    idle(); set_h0(CSR, 1, 0);
    #1 vecs++; if (obs !== 5'b00000) begin errs++; $display("FAIL csr_run: got %b expected %b", obs, 5'b00000); end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      #1 vecs++; if (obs !== 5'b00001) begin errs++; $display("FAIL csr_drain %0d: got %b expected %b", i, obs, 5'b00001); end
      @(negedge clk);
    end
    bus.pipe_empty = 1;
    #1 vecs++; if (obs !== 5'b10011) begin errs++; $display("FAIL csr_issue: got %b expected %b", obs, 5'b10011); end
    @(negedge clk); idle(); bus.pipe_empty = 1; set_pair();
    #1 vecs++; if (obs !== 5'b00001) begin errs++; $display("FAIL wait_hold: got %b expected %b", obs, 5'b00001); end
    @(negedge clk); bus.flush_BR = 1;
    #1 vecs++; if (obs !== 5'b00001) begin errs++; $display("FAIL wait_flush: got %b expected %b", obs, 5'b00001); end
    @(negedge clk); bus.flush_BR = 0; bus.ser_done = 1;
    #1 vecs++; if (obs !== 5'b00001) begin errs++; $display("FAIL wait_done: got %b expected %b", obs, 5'b00001); end
    @(negedge clk); bus.ser_done = 0;
    #1 vecs++; if (obs !== 5'b11100) begin errs++; $display("FAIL resume: got %b expected %b", obs, 5'b11100); end
    @(negedge clk); idle();
  endtask

  task automatic test_stall_flush();
    idle(); set_pair(); bus.stall = 1;
    #1 vecs++; if (obs !== 5'b00000) begin errs++; $display("FAIL stall: got %b expected %b", obs, 5'b00000); end
    @(negedge clk); bus.stall = 0; bus.flush_BR = 1;
    #1 vecs++; if (obs !== 5'b00000) begin errs++; $display("FAIL flush: got %b expected %b", obs, 5'b00000); end
    @(negedge clk); idle(); set_h0(CSR, 1, 0); bus.pipe_empty = 1; bus.stall = 1;
    #1 vecs++; if (obs !== 5'b00000) begin errs++; $display("FAIL csr_stalled_run: got %b expected %b", obs, 5'b00000); end
    @(negedge clk);
    #1 vecs++; if (obs !== 5'b00001) begin errs++; $display("FAIL drain_stall: got %b expected %b", obs, 5'b00001); end
    @(negedge clk); bus.stall = 0; bus.flush_BR = 1;
    #1 vecs++; if (obs !== 5'b00001) begin errs++; $display("FAIL drain_flush: got %b expected %b", obs, 5'b00001); end
    @(negedge clk); idle(); set_pair(); bus.pipe_empty = 1;
    #1 vecs++; if (obs !== 5'b11100) begin errs++; $display("FAIL after_drain_flush: got %b expected %b", obs, 5'b11100); end
    @(negedge clk); idle();
  endtask

  task automatic test_rst_wait();
    idle(); set_h0(DIV, 1, 1);
    #1 vecs++; if (obs !== 5'b10010) begin errs++; $display("FAIL div_before_rst: got %b expected %b", obs, 5'b10010); end
    @(negedge clk); set_h0(CSR, 1, 0);
    #1 vecs++; if (obs !== 5'b00000) begin errs++; $display("FAIL csr_run2: got %b expected %b", obs, 5'b00000); end
    @(negedge clk); bus.pipe_empty = 1;
    #1 vecs++; if (obs !== 5'b10011) begin errs++; $display("FAIL drain_issue2: got %b expected %b", obs, 5'b10011); end
    @(negedge clk); idle(); set_h0(MUL, 1, 2);
    #1 vecs++; if (obs !== 5'b00001) begin errs++; $display("FAIL wait_before_rst: got %b expected %b", obs, 5'b00001); end
    #2 rst = 1;
    #1 vecs++; if (obs !== 5'b00000) begin errs++; $display("FAIL rst_in_wait: got %b expected %b", obs, 5'b00000); end
    @(negedge clk); rst = 0;
    #1 vecs++; if (obs !== 5'b00000) begin errs++; $display("FAIL first_after_rst: got %b expected %b", obs, 5'b00000); end
    @(negedge clk);
    #1 vecs++; if (obs !== 5'b10010) begin errs++; $display("FAIL mul_after_rst: got %b expected %b", obs, 5'b10010); end
    @(negedge clk); idle();
  endtask

  function automatic logic [9:0] rnd_type();
    int r;
    r = $urandom_range(0, 99);
    return r < 45 ? ALU : r < 55 ? BR : r < 68 ? MUL : r < 78 ? DIV : r < 93 ? MEM
         : r < 96 ? CSR : r < 98 ? ERTN : CACOP;
  endfunction

  function automatic bit serial(input logic [9:0] t);
    return t == CSR || t == ERTN || t == CACOP;
  endfunction

  // A mul/div is held off for DIVC cycles after the cycle a div issued.
  function automatic bit blocked(input logic [9:0] t, input int cyc, input int last_div);
    return (t == MUL || t == DIV) && cyc - last_div <= DIVC;
  endfunction

  function automatic bit pairable(input int cyc, input int last_div);
    bit both_non_alu, raw, waw;
    both_non_alu = bus.h0_type != ALU && bus.h1_type != ALU;
    raw = bus.h0_rf_we && bus.h0_rd != 0 && (bus.h0_rd == bus.h1_raddr1 || bus.h0_rd == bus.h1_raddr2);
    waw = bus.h0_rf_we && bus.h1_rf_we && bus.h1_rd != 0 && bus.h0_rd == bus.h1_rd;
    return bus.h1_valid && !serial(bus.h1_type) && !both_non_alu && !raw && !waw
           && !blocked(bus.h1_type, cyc, last_div);
  endfunction

  task automatic test_random(input int n);
    int mode, cyc, last_div;
    bit fresh;
    logic e1, e2;
    logic [4:0] exp;
    idle(); rst = 1;
    @(negedge clk); rst = 0;
    mode = 0; cyc = 0; last_div = -1000; fresh = 1;
    for (int i = 0; i < n; i++) begin
      bus.h0_valid = $urandom_range(0, 99) < 85; bus.h0_type = rnd_type();
      bus.h0_rf_we = $urandom_range(0, 1) == 1; bus.h0_rd = 5'($urandom_range(0, 7));
      bus.h1_valid = $urandom_range(0, 99) < 85; bus.h1_type = rnd_type();
      bus.h1_rf_we = $urandom_range(0, 1) == 1; bus.h1_rd = 5'($urandom_range(0, 7));
      bus.h1_raddr1 = 5'($urandom_range(0, 7)); bus.h1_raddr2 = 5'($urandom_range(0, 7));
      bus.stall = $urandom_range(0, 99) < 10; bus.flush_BR = $urandom_range(0, 99) < 5;
      bus.pipe_empty = $urandom_range(0, 1) == 1; bus.ser_done = $urandom_range(0, 99) < 15;
      #1;
      e1 = 0; e2 = 0;
      if (!fresh && !bus.stall && !bus.flush_BR) begin
        if (mode == 0 && bus.h0_valid && !serial(bus.h0_type) && !blocked(bus.h0_type, cyc, last_div)) begin
          e1 = 1; e2 = pairable(cyc, last_div);
        end else if (mode == 1) e1 = bus.pipe_empty;
      end
      exp = {e1, e2, 2'(e1) + 2'(e2), mode != 0};
      vecs++;
      if (obs !== exp) begin errs++; $display("FAIL random cycle %0d (mode %0d): got %b expected %b", i, mode, obs, exp); end
      if (!fresh) begin
        if (mode == 0) begin if (bus.h0_valid && serial(bus.h0_type)) mode = 1; end
        else if (mode == 1) begin if (bus.flush_BR) mode = 0; else if (e1) mode = 2; end
        else if (bus.ser_done) mode = 0;
      end
      if ((e1 && bus.h0_type == DIV) || (e2 && bus.h1_type == DIV)) last_div = cyc;
      cyc++; fresh = 0;
      @(negedge clk);
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_pair();
    test_raw();
    test_nonalu();
    test_serial();
    test_stall_flush();
    test_rst_wait();
    test_random(3000);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
